register_file_sb: RTL and testbench

- Parametrised multi-read-port register file with write-to-read bypass, optional hardwired-zero register 0, and an integrated pending-write scoreboard.
- Sits in the CPU datapath between decode and writeback.
- Decode reads operands and busy flags, and marks destinations pending at issue.
- Writeback retires a write and clears the pending flag.
- Array and scoreboard clear on asynchronous active-low reset.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 69 ++++++
 rtl/register_file_sb.sv | 93 +++++++++
 tb/tb_register_file_sb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and helpers for the register file slice.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default register width and address width
//   MAX_NUM_READ                    : largest supported number of read ports
//   slice_lsb()                     : LSB position of port k inside a packed bus
package rf_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int MAX_NUM_READ   = 4;

  // Packed per-port buses place port k at [k*width +: width].
  function automatic int unsigned slice_lsb(input int unsigned port,
                                            input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one pending bit per architectural register plus a
// registered population count of those bits.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, wr_addr      writeback retire: clears the pending bit
//   sb_set_en/addr      issue: marks a destination pending
//   sb_flush            clears every pending bit (beats a same-cycle set)
//   pending             current pending bit vector
//   busy_count          number of pending bits, 0..2**ADDR_WIDTH
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic                      sb_set_en,
  input  logic [ADDR_WIDTH-1:0]     sb_set_addr,
  input  logic                      sb_flush,
  output logic [2**ADDR_WIDTH-1:0]  pending,
  output logic [ADDR_WIDTH:0]       busy_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0]  pending_reg;
  logic [DEPTH-1:0]  pending_next;
  logic [ADDR_WIDTH:0] count_reg;
  logic [ADDR_WIDTH:0] count_next;
  logic              set_ok;

  // The zero register can never become pending.
  assign set_ok = sb_set_en && !((ZERO_REG != 0) && (sb_set_addr == '0));

  // Order matters: retire clears first, then a same-address issue re-sets
  // the bit (newer issue wins), and a flush overrides both.
  always_comb begin
    pending_next = pending_reg;
    if (wr_en) pending_next[wr_addr] = 1'b0;
    if (set_ok) pending_next[sb_set_addr] = 1'b1;
    if (sb_flush) pending_next = '0;
  end

  // Count the next-state bits so the registered count lands on the same
  // edge as the bits themselves.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + {{ADDR_WIDTH{1'b0}}, pending_next[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
      count_reg   <= '0;
    end else begin
      pending_reg <= pending_next;
      count_reg   <= count_next;
    end
  end

  assign pending    = pending_reg;
  assign busy_count = count_reg;

endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: multi-read-port register file with same-cycle write
// bypass, optional hardwired-zero register 0 and a pending-write scoreboard.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data writeback write port
//   rd_addr               packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data               packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_busy               per-port pending flag for the addressed register
//   sb_set_en/sb_set_addr issue-time pending mark
//   sb_flush              clear all pending flags
//   busy_count            number of registers currently pending
module register_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]            rd_busy,
  input  logic                           sb_set_en,
  input  logic [ADDR_WIDTH-1:0]          sb_set_addr,
  input  logic                           sb_flush,
  output logic [ADDR_WIDTH:0]            busy_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic                  wr_allowed;

  // Writes to the hardwired zero register are dropped.
  assign wr_allowed = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // Storage is cleared by reset, so it is built from flops rather than RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_allowed) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .sb_flush    (sb_flush),
    .pending     (pending),
    .busy_count  (busy_count)
  );

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  is_zero;
    logic                  wr_hit;

    assign addr    = rd_addr[slice_lsb(gi, ADDR_WIDTH) +: ADDR_WIDTH];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    // Forwarding is suppressed while reset is held so reads show the
    // cleared array, not the in-flight write that will never land.
    assign wr_hit  = (BYPASS != 0) && rst_n && wr_en && (wr_addr == addr);

    always_comb begin
      data = mem_reg[addr];
      if (wr_hit)  data = wr_data;
      if (is_zero) data = '0;
    end

    assign rd_data[slice_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] = data;
    // A matching write retires the register this cycle, so it is not busy.
    assign rd_busy[gi] = pending[addr] && !wr_hit && !is_zero;
  end

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr;
  logic        sb_flush;
  logic [5:0]  busy_count, busy_count_nb;

  int n_pass  = 0;
  int n_total = 0;

  // Default instance (BYPASS=1, ZERO_REG=1) and a no-bypass twin on the same inputs.
  register_file_sb dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush),
    .busy_count(busy_count)
  );

  register_file_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush),
    .busy_count(busy_count_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_mem [32];
  bit          m_pend [int];   // set of pending register numbers

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_pend.delete();
  endfunction

  function automatic logic [31:0] model_rd(input int a, input bit bypass);
    if (a == 0) return '0;
    if (bypass && wr_en && int'(wr_addr) == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic model_busy(input int a, input bit bypass);
    if (a == 0) return 1'b0;
    if (bypass && wr_en && int'(wr_addr) == a) return 1'b0;
    return m_pend.exists(a);
  endfunction

  // Effect of one clock edge with the currently driven inputs.
  function automatic void model_step();
    if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
    if (sb_flush) begin
      m_pend.delete();
    end else begin
      if (wr_en) m_pend.delete(int'(wr_addr));
      if (sb_set_en && sb_set_addr != 0) m_pend[int'(sb_set_addr)] = 1'b1;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic se, input logic [4:0] sa, input logic fl);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr = {r1, r0};
    sb_set_en = se; sb_set_addr = sa; sb_flush = fl;
    #1;
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < 2; k++) begin
      int a;
      a = int'(rd_addr[k*5 +: 5]);
      check($sformatf("%s rd%0d", tag, k), rd_data[k*32 +: 32], model_rd(a, 1'b1));
      check($sformatf("%s busy%0d", tag, k), {31'b0, rd_busy[k]}, {31'b0, model_busy(a, 1'b1)});
      check($sformatf("%s nb_rd%0d", tag, k), rd_data_nb[k*32 +: 32], model_rd(a, 1'b0));
      check($sformatf("%s nb_busy%0d", tag, k), {31'b0, rd_busy_nb[k]}, {31'b0, model_busy(a, 1'b0)});
    end
    check($sformatf("%s cnt", tag), {26'b0, busy_count}, m_pend.num());
    check($sformatf("%s nb_cnt", tag), {26'b0, busy_count_nb}, m_pend.num());
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic        se;
    logic [4:0]  sa;
    logic        fl;
    logic [31:0] e_rd;
    logic [31:0] e_rd_nb;
    logic        e_busy;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs [17];

  initial begin
    // Expected values are the outputs seen before the edge of that row.
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0};
    vecs[1]  = '{0, 0, 32'h0,        5, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    vecs[2]  = '{1, 0, 32'h12345678, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0};
    vecs[3]  = '{0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        32'h0,        0, 0};
    vecs[4]  = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, 0};
    vecs[5]  = '{0, 0, 32'h0,        7, 1, 7, 0, 32'h0,        32'h0,        0, 0};
    vecs[6]  = '{0, 0, 32'h0,        7, 0, 0, 0, 32'h0,        32'h0,        1, 1};
    vecs[7]  = '{1, 7, 32'hCAFEF00D, 7, 1, 7, 0, 32'hCAFEF00D, 32'h0,        0, 1};
    vecs[8]  = '{0, 0, 32'h0,        7, 0, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1};
    vecs[9]  = '{1, 7, 32'h11111111, 7, 0, 0, 0, 32'h11111111, 32'hCAFEF00D, 0, 1};
    vecs[10] = '{0, 0, 32'h0,        7, 0, 0, 0, 32'h11111111, 32'h11111111, 0, 0};
    vecs[11] = '{0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        32'h0,        0, 0};
    vecs[12] = '{0, 0, 32'h0,        1, 1, 2, 0, 32'h0,        32'h0,        1, 1};
    vecs[13] = '{0, 0, 32'h0,        2, 1, 3, 0, 32'h0,        32'h0,        1, 2};
    vecs[14] = '{0, 0, 32'h0,        3, 1, 4, 1, 32'h0,        32'h0,        1, 3};
    vecs[15] = '{0, 0, 32'h0,        4, 0, 0, 0, 32'h0,        32'h0,        0, 0};
    vecs[16] = '{0, 0, 32'h0,        3, 0, 0, 0, 32'h0,        32'h0,        0, 0};

    rst_n = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
    sb_set_en = 0; sb_set_addr = 0; sb_flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Every address on both ports reads cleared after reset.
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 5'(a), 5'(31 - a), 0, 0, 0);
      check($sformatf("rst rd0 a%0d", a), rd_data[31:0], 32'h0);
      check($sformatf("rst rd1 a%0d", a), rd_data[63:32], 32'h0);
      check($sformatf("rst busy a%0d", a), {30'b0, rd_busy}, 32'h0);
      check($sformatf("rst cnt a%0d", a), {26'b0, busy_count}, 32'h0);
      model_step();
    end

    // Directed table: bypass, zero register, set/clear race, flush priority.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].ra,
            vecs[i].se, vecs[i].sa, vecs[i].fl);
      check($sformatf("vec%0d rd0", i), rd_data[31:0], vecs[i].e_rd);
      check($sformatf("vec%0d rd1dup", i), rd_data[63:32], vecs[i].e_rd);
      check($sformatf("vec%0d nb_rd0", i), rd_data_nb[31:0], vecs[i].e_rd_nb);
      check($sformatf("vec%0d busy0", i), {31'b0, rd_busy[0]}, {31'b0, vecs[i].e_busy});
      check($sformatf("vec%0d busy1dup", i), {31'b0, rd_busy[1]}, {31'b0, vecs[i].e_busy});
      check($sformatf("vec%0d cnt", i), {26'b0, busy_count}, {26'b0, vecs[i].e_cnt});
      model_step();
    end

    // Randomized traffic against the model; addresses often narrowed to force collisions.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa, r0, r1, sa;
      bit narrow;
      narrow = ($urandom_range(0, 3) != 0);
      wa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r0 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom_range(0, 7));
      sa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      drive(1'($urandom), wa, $urandom, r0, r1,
            1'($urandom_range(0, 2) != 0), sa, ($urandom_range(0, 15) == 0));
      check_model($sformatf("rnd%0d", i));
      model_step();
    end

    // Fill all registers pending to reach the top of the count range.
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 5'(a), 0, 1, 5'(a), 0);
      model_step();
    end
    drive(0, 0, 0, 5'd31, 5'd1, 0, 0, 0);
    check_model("full");
    model_step();

    // Asynchronous reset between edges while a write is being presented.
    drive(1, 9, 32'hA5A5A5A5, 9, 9, 1, 9, 1);
    model_step();
    drive(0, 0, 0, 9, 9, 1, 10, 0);
    check_model("pre_arst");
    model_step();
    drive(1, 9, 32'hFFFFFFFF, 9, 10, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst rd9", rd_data[31:0], 32'h0);
    check("arst nb_rd9", rd_data_nb[31:0], 32'h0);
    check("arst busy", {30'b0, rd_busy}, 32'h0);
    check("arst cnt", {26'b0, busy_count}, 32'h0);
    @(posedge clk);
    #1;
    check("arst hold rd9", rd_data[31:0], 32'h0);
    check("arst hold nb_rd9", rd_data_nb[31:0], 32'h0);
    check("arst hold cnt", {26'b0, busy_count}, 32'h0);
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    drive(0, 0, 0, 9, 10, 0, 0, 0);
    check_model("post_arst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
